// File: rtl/jelly_pack_arbiter_pkg.sv
// Shared helpers for jelly_pack_arbiter: width derivation and packed-word field offsets.
package jelly_pack_arbiter_pkg;

   localparam int DATA_LSB = 0;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

   function automatic int bits(input int w);
      return (w > 0) ? w : 1;
   endfunction

   function automatic int id_width(input int n_ports);
      return (n_ports > 1) ? clog2(n_ports) : 0;
   endfunction

   function automatic int id_lsb(input int data_width);
      return data_width;
   endfunction

   function automatic int user_lsb(input int data_width, input int id_w);
      return data_width + id_w;
   endfunction

endpackage

// File: rtl/jelly_pack_arbiter_rr_select.sv
// Round-robin grant search: rotate the doubled request vector by ptr, then priority-encode.
module jelly_pack_arbiter_rr_select #(
   parameter int N_PORTS = 4,
   parameter int PTR_W   = 2
) (
   input  logic [N_PORTS-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [PTR_W-1:0]   grant,
   output logic               grant_valid
);

   localparam logic [PTR_W:0] N_VAL = (PTR_W+1)'(N_PORTS);

   logic [N_PORTS-1:0] rotated;
   logic [PTR_W:0]     offset;
   logic [PTR_W:0]     sum;

   assign rotated = N_PORTS'({req, req} >> ptr);

   always_comb begin
      grant_valid = 1'b0;
      offset      = '0;
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            grant_valid = 1'b1;
            offset      = (PTR_W+1)'(i);
         end
      end
      sum = {1'b0, ptr} + offset;
      if (sum >= N_VAL) sum = sum - N_VAL;
      grant = sum[PTR_W-1:0];
   end

endmodule

// File: rtl/jelly_pack_arbiter.sv
// Round-robin arbiter packing {user, id, data} into one registered output stream.
// Define JELLY_PACK_ARBITER_LOCK_EN to hold the grant on one port until its s_last beat.
module jelly_pack_arbiter
   import jelly_pack_arbiter_pkg::*;
#(
   parameter int N_PORTS    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 0
) (
   input  logic                                 aresetn,
   input  logic                                 aclk,
   input  logic                                 cke,
   input  logic [N_PORTS*DATA_WIDTH-1:0]        s_data,
   input  logic [N_PORTS*bits(USER_WIDTH)-1:0]  s_user,
   input  logic [N_PORTS-1:0]                   s_last,
   input  logic [N_PORTS-1:0]                   s_valid,
   output logic [N_PORTS-1:0]                   s_ready,
   output logic [DATA_WIDTH+id_width(N_PORTS)+USER_WIDTH-1:0] m_data,
   output logic                                 m_last,
   output logic                                 m_valid,
   input  logic                                 m_ready
);

   localparam int ID_WIDTH = id_width(N_PORTS);
   localparam int M_WIDTH  = DATA_WIDTH + ID_WIDTH + USER_WIDTH;
   localparam int PTR_W    = bits(ID_WIDTH);
   localparam int UW       = bits(USER_WIDTH);
   localparam int ID_LSB   = id_lsb(DATA_WIDTH);
   localparam int USER_LSB = user_lsb(DATA_WIDTH, ID_WIDTH);
   localparam logic [PTR_W:0] N_VAL = (PTR_W+1)'(N_PORTS);

   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      sel_ptr;
   logic [N_PORTS-1:0]    sel_req;
   logic [PTR_W-1:0]      grant;
   logic                  grant_valid;
   logic                  load;
   logic                  accept;
   logic [PTR_W:0]        inc;
   logic [PTR_W-1:0]      next_ptr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [UW-1:0]         sel_user;
   logic [M_WIDTH-1:0]    packed_word;

`ifdef JELLY_PACK_ARBITER_LOCK_EN
   logic             lock;
   logic [PTR_W-1:0] lock_port;

   // While locked, only the locked port may win and the search starts at it.
   assign sel_req = lock ? (s_valid & (N_PORTS'(1) << lock_port)) : s_valid;
   assign sel_ptr = lock ? lock_port : ptr;
`else
   assign sel_req = s_valid;
   assign sel_ptr = ptr;
`endif

   jelly_pack_arbiter_rr_select #(
      .N_PORTS (N_PORTS),
      .PTR_W   (PTR_W)
   ) u_rr_select (
      .req         (sel_req),
      .ptr         (sel_ptr),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // Reset gates load so nothing is accepted while the output register is held clear.
   assign load     = aresetn & cke & (~m_valid | m_ready);
   assign accept   = load & grant_valid;
   assign s_ready  = accept ? (N_PORTS'(1) << grant) : '0;
   assign inc      = {1'b0, grant} + (PTR_W+1)'(1);
   assign next_ptr = (inc == N_VAL) ? '0 : inc[PTR_W-1:0];

   assign sel_data = s_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
   assign sel_user = s_user[int'(grant)*UW +: UW];

   assign packed_word[DATA_LSB +: DATA_WIDTH] = sel_data;
   generate
      if (ID_WIDTH > 0) begin : g_id
         assign packed_word[ID_LSB +: ID_WIDTH] = grant;
      end
      if (USER_WIDTH > 0) begin : g_user
         assign packed_word[USER_LSB +: USER_WIDTH] = sel_user;
      end else begin : g_no_user
         logic unused_user;
         assign unused_user = ^sel_user;
      end
   endgenerate

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_valid   <= 1'b0;
         m_data    <= '0;
         m_last    <= 1'b0;
         ptr       <= '0;
`ifdef JELLY_PACK_ARBITER_LOCK_EN
         lock      <= 1'b0;
         lock_port <= '0;
`endif
      end else if (load) begin
         m_valid <= grant_valid;
         if (grant_valid) begin
            m_data <= packed_word;
            m_last <= s_last[grant];
`ifdef JELLY_PACK_ARBITER_LOCK_EN
            if (s_last[grant]) begin
               lock <= 1'b0;
               ptr  <= next_ptr;
            end else begin
               lock      <= 1'b1;
               lock_port <= grant;
            end
`else
            ptr <= next_ptr;
`endif
         end
      end
   end

endmodule

// File: tb/tb_jelly_pack_arbiter.sv
// Directed bench for jelly_pack_arbiter with an expected-beat queue on the 4-port output.
module tb_jelly_pack_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int MW = 34;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic cke = 1'b1;
   always #5 aclk = ~aclk;

   logic [N*DW-1:0] s_data;
   logic [N-1:0]    s_user, s_last, s_valid, s_ready;
   logic [MW-1:0]   m_data;
   logic            m_last, m_valid, m_ready;

   logic [23:0] s_data3;
   logic [5:0]  s_user3;
   logic [2:0]  s_last3, s_valid3, s_ready3;
   logic [11:0] m_data3;
   logic        m_last3, m_valid3, m_ready3;

   int passed = 0;
   int failed = 0;
   int total  = 0;
   logic [MW:0] exp_q[$];

   jelly_pack_arbiter #(.N_PORTS(4), .DATA_WIDTH(32), .USER_WIDTH(0)) u_dut (
      .aresetn (aresetn), .aclk (aclk), .cke (cke),
      .s_data (s_data), .s_user (s_user), .s_last (s_last),
      .s_valid (s_valid), .s_ready (s_ready),
      .m_data (m_data), .m_last (m_last), .m_valid (m_valid), .m_ready (m_ready)
   );

   jelly_pack_arbiter #(.N_PORTS(3), .DATA_WIDTH(8), .USER_WIDTH(2)) u_dut3 (
      .aresetn (aresetn), .aclk (aclk), .cke (cke),
      .s_data (s_data3), .s_user (s_user3), .s_last (s_last3),
      .s_valid (s_valid3), .s_ready (s_ready3),
      .m_data (m_data3), .m_last (m_last3), .m_valid (m_valid3), .m_ready (m_ready3)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [MW:0] beat(input int id, input logic [31:0] d, input logic last);
      return {last, id[1:0], d};
   endfunction

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   always @(negedge aclk) begin
      if (aresetn && cke && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            failed++;
            $error("FAIL unexpected_beat observed=%0h expected=none", {m_last, m_data});
         end else begin
            chk("out_beat", 64'({m_last, m_data}), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      for (int i = 0; i < N; i++) s_data[i*DW +: DW] = 32'hA0 + 32'(i);
      s_user   = '0;
      s_last   = '0;
      s_valid  = '0;
      m_ready  = 1'b1;
      s_data3  = {8'h32, 8'h31, 8'h30};
      s_user3  = {2'd1, 2'd2, 2'd3};
      s_last3  = '0;
      s_valid3 = '0;
      m_ready3 = 1'b1;

      // reset with random requests
      for (int r = 0; r < 3; r++) begin
         @(negedge aclk);
         s_valid  = 4'($urandom);
         s_valid3 = 3'($urandom);
         #1;
         chk("rst_m_valid", 64'(m_valid), 64'(0));
         chk("rst_m_data", 64'(m_data), 64'(0));
         chk("rst_s_ready", 64'(s_ready), 64'(0));
         chk("rst_s_ready3", 64'(s_ready3), 64'(0));
      end
      step();
      aresetn  = 1'b1;
      s_valid  = '0;
      s_valid3 = '0;
      step();

      // all ports request, port 3 marks last
      s_valid = 4'hF;
      s_last  = 4'b1000;
      for (int k = 0; k < 8; k++) begin
         @(negedge aclk);
         chk("rr_ready", 64'(s_ready), 64'(1 << (k % 4)));
         exp_q.push_back(beat(k % 4, 32'hA0 + 32'(k % 4), (k % 4) == 3));
         step();
      end
      s_valid = '0;
      s_last  = '0;
      repeat (3) step();
      chk("rr_drain", 64'(exp_q.size()), 64'(0));
      chk("rr_idle", 64'(m_valid), 64'(0));

      // backpressure with ports 1 and 3
      s_valid = 4'b1010;
      m_ready = 1'b0;
      @(negedge aclk);
      chk("bp_first_ready", 64'(s_ready), 64'(4'b0010));
      exp_q.push_back(beat(1, 32'hA1, 1'b0));
      step();
      for (int k = 0; k < 5; k++) begin
         @(negedge aclk);
         chk("bp_stall_ready", 64'(s_ready), 64'(0));
         chk("bp_hold", 64'({m_valid, m_last, m_data}), 64'({1'b1, beat(1, 32'hA1, 1'b0)}));
         step();
      end
      m_ready = 1'b1;
      @(negedge aclk);
      chk("bp_resume_ready", 64'(s_ready), 64'(4'b1000));
      exp_q.push_back(beat(3, 32'hA3, 1'b0));
      step();
      s_valid = '0;
      repeat (3) step();
      chk("bp_drain", 64'(exp_q.size()), 64'(0));

      // clock enable freeze mid-stream
      s_valid = 4'hF;
      for (int k = 0; k < 2; k++) begin
         @(negedge aclk);
         chk("cke_pre_ready", 64'(s_ready), 64'(1 << k));
         exp_q.push_back(beat(k, 32'hA0 + 32'(k), 1'b0));
         step();
      end
      cke = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge aclk);
         chk("cke_ready", 64'(s_ready), 64'(0));
         chk("cke_hold", 64'({m_valid, m_last, m_data}), 64'({1'b1, beat(1, 32'hA1, 1'b0)}));
         step();
      end
      cke = 1'b1;
      for (int k = 2; k < 4; k++) begin
         @(negedge aclk);
         chk("cke_post_ready", 64'(s_ready), 64'(1 << k));
         exp_q.push_back(beat(k, 32'hA0 + 32'(k), 1'b0));
         step();
      end
      s_valid = '0;
      repeat (3) step();
      chk("cke_drain", 64'(exp_q.size()), 64'(0));

      // three-port wrap with user field
      s_valid3 = 3'b010;
      @(negedge aclk);
      chk("w3_ready_a", 64'(s_ready3), 64'(3'b010));
      step();
      s_valid3 = 3'b011;
      @(negedge aclk);
      chk("w3_wrap_grant", 64'(s_ready3), 64'(3'b001));
      chk("w3_out_a", 64'({m_valid3, m_data3}), 64'({1'b1, 2'd2, 2'd1, 8'h31}));
      step();
      @(negedge aclk);
      chk("w3_ptr_after", 64'(s_ready3), 64'(3'b010));
      chk("w3_out_b", 64'({m_valid3, m_data3}), 64'({1'b1, 2'd3, 2'd0, 8'h30}));
      step();
      s_valid3 = '0;
      @(negedge aclk);
      chk("w3_out_c", 64'({m_valid3, m_data3}), 64'({1'b1, 2'd2, 2'd1, 8'h31}));
      step();

`ifdef JELLY_PACK_ARBITER_LOCK_EN
      // port 2 packet of three beats with a two-cycle gap
      s_valid = 4'b0100;
      s_last  = 4'b0000;
      s_data[2*DW +: DW] = 32'hB0;
      @(negedge aclk);
      chk("lock_b0_ready", 64'(s_ready), 64'(4'b0100));
      exp_q.push_back(beat(2, 32'hB0, 1'b0));
      step();
      s_valid = 4'b0011;
      @(negedge aclk);
      chk("lock_gap_ready", 64'(s_ready), 64'(0));
      step();
      @(negedge aclk);
      chk("lock_gap_ready", 64'(s_ready), 64'(0));
      chk("lock_bubble", 64'(m_valid), 64'(0));
      step();
      s_valid = 4'b0111;
      s_data[2*DW +: DW] = 32'hB1;
      @(negedge aclk);
      chk("lock_b1_ready", 64'(s_ready), 64'(4'b0100));
      exp_q.push_back(beat(2, 32'hB1, 1'b0));
      step();
      s_data[2*DW +: DW] = 32'hB2;
      s_last = 4'b0100;
      @(negedge aclk);
      chk("lock_b2_ready", 64'(s_ready), 64'(4'b0100));
      exp_q.push_back(beat(2, 32'hB2, 1'b1));
      step();
      s_valid = 4'b0011;
      s_last  = '0;
      @(negedge aclk);
      chk("lock_release", 64'(s_ready), 64'(4'b0001));
      exp_q.push_back(beat(0, 32'hA0, 1'b0));
      step();
      s_valid = '0;
      repeat (3) step();
      chk("lock_drain", 64'(exp_q.size()), 64'(0));
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
